// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type sequencer and decoder: FSM states,
// ALU operation codes and instruction-field constants.
package rtype_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

endpackage

// File: rtl/rtype_seq_ctrl_if.sv
// Instruction-memory fetch handshake plus register-file/ALU control bundle.
// master = sequencer side, slave = memory/datapath side.
interface rtype_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic [3:0]  alu_op;

  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op,
    input  imem_valid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op,
    output imem_valid, imem_rdata
  );
endinterface

// File: rtl/rtype_decode.sv
// Combinational R-type decoder: instruction word -> legality, halt word,
// ALU op and register indices. Kept stateless so a single-cycle core can reuse it.
module rtype_decode
  import rtype_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal,
  output logic        halt,
  output logic [3:0]  alu_op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign alt    = (funct7 == F7_ALT);
  assign halt   = (ir == 32'h0);

  // The alternate funct7 only selects SUB and SRA.
  assign legal = (opcode == OPC_RTYPE) &&
                 ((funct7 == F7_BASE) ||
                  (alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end
endmodule

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle R-type sequencer: FETCH/DECODE/EXEC/WB loop over instruction memory.
// Optional retired-instruction counter enabled by defining RTYPE_PERF_CNT_EN.
module rtype_seq_ctrl
  import rtype_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  rtype_seq_ctrl_if.master  bus,
  output logic              busy,
  output logic              illegal
`ifdef RTYPE_PERF_CNT_EN
  ,
  output logic [31:0]       retired
`endif
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        go;

  logic       dec_legal, dec_halt;
  logic [3:0] dec_alu_op;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;

  rtype_decode u_dec (
    .ir     (ir_q),
    .legal  (dec_legal),
    .halt   (dec_halt),
    .alu_op (dec_alu_op),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .rd     (dec_rd)
  );

  assign go = start && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: if (go) begin
        state_d   = S_FETCH;
        pc_d      = PC_RESET;
        illegal_d = 1'b0;
      end
      S_FETCH: if (bus.imem_valid) begin
        ir_d    = bus.imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + 32'(PC_STEP);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      ir_q      <= 32'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef RTYPE_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Only legal instructions reach WB, so every WB counts (rd=0 included).
  always_comb begin
    retired_d = retired_q;
    if (go)                   retired_d = 32'h0;
    else if (state_q == S_WB) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= 32'h0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.rf_raddr1 = dec_rs1;
  assign bus.rf_raddr2 = dec_rs2;
  assign bus.rf_waddr  = dec_rd;
  assign bus.alu_op    = dec_alu_op;
  assign bus.rf_we     = (state_q == S_WB) && (dec_rd != 5'd0);
  assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
  assign illegal       = illegal_q;
endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Directed bench for rtype_seq_ctrl; a second instance starting near the top
// of the address space covers PC wrap.
module tb_rtype_seq_ctrl;
  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SUB  = 32'h40208233;
  localparam logic [31:0] W_SRA  = 32'h4020D2B3;
  localparam logic [31:0] W_ADD0 = 32'h00208033;
  localparam logic [31:0] W_ADDI = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, illegal, busy2, illegal2;
  int   checks = 0;
  int   failures = 0;

  rtype_seq_ctrl_if bus ();
  rtype_seq_ctrl_if bus2 ();

`ifdef RTYPE_PERF_CNT_EN
  logic [31:0] retired, retired2;
`endif

  rtype_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .illegal(illegal)
`ifdef RTYPE_PERF_CNT_EN
    , .retired(retired)
`endif
  );

  rtype_seq_ctrl #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2),
    .busy(busy2), .illegal(illegal2)
`ifdef RTYPE_PERF_CNT_EN
    , .retired(retired2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.imem_valid = 1'b0;  bus.imem_rdata = 32'h0;
    bus2.imem_valid = 1'b1; bus2.imem_rdata = W_ADD;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_aluop", bus.alu_op, 0);
    chk("rst_pc", bus.imem_addr, 32'h0);
`ifdef RTYPE_PERF_CNT_EN
    chk("rst_retired", retired, 0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_req", bus.imem_req, 0);

    // ADD x3,x1,x2 with immediate valid
    start = 1'b1; bus.imem_valid = 1'b1; bus.imem_rdata = W_ADD;
    tick(); start = 1'b0;
    chk("add_f_req", bus.imem_req, 1);
    chk("add_f_addr", bus.imem_addr, 32'h0);
    chk("add_f_busy", busy, 1);
    chk("wrap_f_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("add_d_ra1", bus.rf_raddr1, 1);
    chk("add_d_ra2", bus.rf_raddr2, 2);
    chk("add_d_we", bus.rf_we, 0);
    chk("add_d_req", bus.imem_req, 0);
    tick();
    chk("add_e_aluop", bus.alu_op, 0);
    tick();
    chk("add_wb_we", bus.rf_we, 1);
    chk("add_wb_waddr", bus.rf_waddr, 3);
    bus.imem_valid = 1'b0; bus.imem_rdata = W_SUB;
    tick();
    chk("add_next_addr", bus.imem_addr, 32'h4);
    chk("add_next_req", bus.imem_req, 1);
    chk("add_next_we", bus.rf_we, 0);
    chk("wrap_next_addr", bus2.imem_addr, 32'h0);

    // SUB with imem_valid low for 3 cycles
    tick();
    chk("stall_c2_req", bus.imem_req, 1);
    chk("stall_c2_addr", bus.imem_addr, 32'h4);
    tick();
    chk("stall_c3_addr", bus.imem_addr, 32'h4);
    tick();
    chk("stall_c4_req", bus.imem_req, 1);
    chk("stall_c4_addr", bus.imem_addr, 32'h4);
    bus.imem_valid = 1'b1;
    tick();
    chk("sub_d_req", bus.imem_req, 0);
    tick();
    chk("sub_e_aluop", bus.alu_op, 1);
    chk("sub_e_we", bus.rf_we, 0);
    tick();
    chk("sub_wb_c7_we", bus.rf_we, 1);
    chk("sub_wb_waddr", bus.rf_waddr, 4);
    bus.imem_rdata = W_SRA;
    tick();
    chk("sra_f_addr", bus.imem_addr, 32'h8);
    tick(); tick();
    chk("sra_e_aluop", bus.alu_op, 7);
    tick();
    chk("sra_wb_we", bus.rf_we, 1);
    chk("sra_wb_waddr", bus.rf_waddr, 5);
    bus.imem_rdata = W_ADD0;
    tick();
    chk("add0_f_addr", bus.imem_addr, 32'hC);
`ifdef RTYPE_PERF_CNT_EN
    chk("retired_3", retired, 3);
`endif

    // add x0: no write, PC still advances
    tick();
    chk("add0_d_we", bus.rf_we, 0);
    tick();
    chk("add0_e_we", bus.rf_we, 0);
    tick();
    chk("add0_wb_we", bus.rf_we, 0);
    chk("add0_wb_busy", busy, 1);
    bus.imem_rdata = W_ADDI;
    tick();
    chk("add0_next_addr", bus.imem_addr, 32'h10);
`ifdef RTYPE_PERF_CNT_EN
    chk("retired_4", retired, 4);
`endif

    // addi is illegal
    tick();
    chk("ill_d_illegal", illegal, 0);
    tick();
    chk("ill_h_illegal", illegal, 1);
    chk("ill_h_busy", busy, 0);
    chk("ill_h_we", bus.rf_we, 0);
    chk("ill_h_req", bus.imem_req, 0);
    tick();
    chk("ill_h2_illegal", illegal, 1);
    chk("ill_h2_busy", busy, 0);
    start = 1'b1; bus.imem_rdata = 32'h0;
    tick(); start = 1'b0;
    chk("restart_illegal", illegal, 0);
    chk("restart_addr", bus.imem_addr, 32'h0);
    chk("restart_req", bus.imem_req, 1);
`ifdef RTYPE_PERF_CNT_EN
    chk("restart_retired", retired, 0);
`endif

    // halt word
    tick(); tick();
    chk("halt_busy", busy, 0);
    chk("halt_illegal", illegal, 0);
    chk("halt_req", bus.imem_req, 0);

    // reset during EXEC of the second instruction
    start = 1'b1; bus.imem_rdata = W_ADD;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("rr_wb_we", bus.rf_we, 1);
    tick();
    chk("rr_f_addr", bus.imem_addr, 32'h4);
    tick(); tick();
    chk("rr_e_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_we", bus.rf_we, 0);
    chk("rr_req", bus.imem_req, 0);
    chk("rr_pc", bus.imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rr_idle_busy", busy, 0);
    chk("rr_idle_req", bus.imem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
